axi4_mem_slave: RTL and testbench
=================================

Name: axi4_mem_slave

Overview:
- AXI4 slave memory model, the responder end of the master port the core drives for icache line refills and uncached fetches.
- Serves INCR/WRAP/FIXED read bursts and INCR write bursts from an internal word-addressed array.
- Read and write channels run independently, one outstanding transaction each.
- Used as the SoC-side instruction/data backing store in simulation and FPGA bring-up.

Parameters:
DEPTH, 16384, memory size in 32-bit words
BASE, 32'h1c00_0000, byte address mapped to word 0
RD_LAT, 2, idle cycles between AR handshake and first R beat (0..15)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
araddr  input  32  read burst start byte address (word aligned)
arlen  input  8  beats minus one
arburst  input  2  0 FIXED, 1 INCR, 2 WRAP
arvalid  input  1  read address valid
arready  output  1  read address accepted
rdata  output  32  read beat data
rresp  output  2  0 OKAY, 3 DECERR
rlast  output  1  final beat of burst
rvalid  output  1  read beat valid
rready  input  1  master accepts beat
awaddr  input  32  write burst start byte address (INCR only)
awlen  input  8  beats minus one
awvalid  input  1  write address valid
awready  output  1  write address accepted
wdata  input  32  write beat data
wstrb  input  4  byte enables
wlast  input  1  master marks final beat
wvalid  input  1  write beat valid
wready  output  1  beat accepted
bresp  output  2  0 OKAY, 2 SLVERR, 3 DECERR
bvalid  output  1  write response valid
bready  input  1  master accepts response

Behaviour:
- Reset (asynchronous, active-low): arready=awready=wready=rvalid=bvalid=rlast=0, rdata=0, rresp=bresp=0, both FSMs idle. Memory contents not reset. Assert mid-burst: burst aborted, no further R/B.
- Address decode: word index = (addr-BASE)>>2; in range iff index < DEPTH (unsigned 32-bit subtract, so addr<BASE wraps large and is out of range).
- Read FSM R_IDLE -> R_WAIT -> R_BEAT -> R_IDLE.
  - R_IDLE: arready=1; on arvalid&arready, latch addr/len/burst, counter=0. Go to R_WAIT if RD_LAT>0, else R_BEAT.
  - R_WAIT: RD_LAT cycles; first beat data registered on exit.
  - R_BEAT: rvalid=1; rdata/rresp/rlast stay stable until rready. On handshake: if counter==arlen, return to R_IDLE (arready=1 next cycle, rvalid=0); else advance address and load the next beat, registered, so rvalid stays high back-to-back.
  - First AR handshake to first rvalid = RD_LAT+1 cycles.
- Beat address: FIXED keeps addr. INCR adds 4, wrapping modulo 2^32. WRAP: len+1 in {2,4,8,16}; addr increments within the (len+1)*4-byte aligned window and wraps to window base. WRAP with other lengths is treated as INCR.
- Per-beat decode: out-of-range beat gives rdata=0, rresp=DECERR. Burst continues to rlast.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1; latch awaddr/awlen, err=OKAY.
  - W_DATA: wready=1. Each handshake writes bytes with wstrb[i]=1 when in range; out-of-range beat sets err=DECERR and drops the write. Address increments by 4.
  - Burst ends on the beat where wlast=1 or counter==awlen. If those disagree, err=SLVERR (DECERR has priority).
  - W_RESP: bvalid=1 and bresp=err held until bready, then W_IDLE.
- Same-cycle read-beat load and write to the same word: read returns old data. Writes are visible to beats loaded in later cycles.
- arready and awready are never asserted while their FSM is busy. The two channels never stall each other.

Decomposition:
- axi_pkg: burst_t enum (FIXED/INCR/WRAP), resp constants OKAY/SLVERR/DECERR, rd_state_t and wr_state_t enums.
- Sub-module axi_burst_addr (combinational next-beat address from addr/len/burst), instantiated once per channel.

Test Plan:
- RD_LAT=2, araddr=BASE+0x10, arlen=3, INCR, rready=1, words 0x10..0x1c preloaded 0xA0..0xA3 -> rvalid on cycle 3 after AR handshake; 4 consecutive beats A0..A3; rlast on 4th beat only; arready returns next cycle.
- WRAP arlen=3 at BASE+0x18 -> beat addresses 0x18, 0x1c, 0x10, 0x14.
- rready toggled 1-0-0-1 mid-burst -> rdata, rresp and rlast held stable while stalled; no beat lost or duplicated.
- awaddr=BASE+0x8, awlen=1, wdata 0x11223344/0x55667788, wstrb 4'b0011/4'b1111 over 0xFFFFFFFF fill -> words 0xFFFF3344, 0x55667788; bresp=OKAY, held until bready.
- Write beat at BASE+4*DEPTH -> memory unchanged, bresp=DECERR. Read of araddr=BASE-4 -> rdata=0, rresp=3.
- awlen=2 with wlast asserted on beat 1 -> bresp=SLVERR. Reset pulsed during an R burst -> rvalid=0 immediately; arready=1 after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 burst/response encodings, channel FSM states and the address decode helper
// for the simulation/bring-up memory slave.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  // Unsigned subtract: addresses below base wrap to a huge index and decode out of range.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat byte address for FIXED/INCR/WRAP bursts; WRAP lengths other than 2/4/8/16
// beats fall back to INCR.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;
  logic        wrap_ok;

  always_comb begin
    incr_addr = addr + 32'd4;
    wrap_ok   = (burst == BURST_WRAP) &&
                ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    // With len+1 a power of two, the window byte mask is simply len*4+3.
    wrap_mask = {22'd0, len, 2'b11};
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if (wrap_ok) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end else begin
      next_addr = incr_addr;
    end
  end

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 memory slave backing store: independent read (FIXED/INCR/WRAP) and write (INCR)
// channels, one outstanding burst each, over a word-addressed array.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_WAIT | counting down RD_LAT idle cycles before the first beat
// R_BEAT | rvalid high, beat registered and held until rready
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, committing beats until wlast or the length count ends the burst
// W_RESP | bvalid high with the accumulated response until bready
module axi4_mem_slave
  import axi_pkg::*;
#(
  parameter int          DEPTH  = 16384,
  parameter logic [31:0] BASE   = 32'h1c00_0000,
  parameter int          RD_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  rd_state_t   rd_state_q, rd_state_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]  rburst_q, rburst_d;
  logic [3:0]  rwait_q, rwait_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d, arready_q, arready_d;
  logic [31:0] rnext, rd_load_addr, r_idx;
  logic        rd_load, rd_load_last, r_in;

  wr_state_t   wr_state_q, wr_state_d;
  logic [31:0] waddr_q, waddr_d, wnext, w_idx;
  logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]  werr_q, werr_d;
  logic        awready_q, awready_d, w_in, w_end, mem_we;

  axi_burst_addr u_rd_addr (.addr(raddr_q), .len(rlen_q), .burst(rburst_q), .next_addr(rnext));
  axi_burst_addr u_wr_addr (.addr(waddr_q), .len(wlen_q), .burst(BURST_INCR), .next_addr(wnext));

  always_comb begin
    rd_state_d   = rd_state_q;
    raddr_d      = raddr_q;
    rlen_d       = rlen_q;
    rburst_d     = rburst_q;
    rcnt_d       = rcnt_q;
    rwait_d      = rwait_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rlast_d      = rlast_q;
    rd_load      = 1'b0;
    rd_load_addr = raddr_q;
    rd_load_last = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          raddr_d  = araddr;
          rlen_d   = arlen;
          rburst_d = arburst;
          rcnt_d   = 8'd0;
          rwait_d  = 4'(RD_LAT - 1);
          if (RD_LAT == 0) begin
            rd_state_d   = R_BEAT;
            rd_load      = 1'b1;
            rd_load_addr = araddr;
            rd_load_last = (arlen == 8'd0);
          end else begin
            rd_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (rwait_q == 4'd0) begin
          rd_state_d   = R_BEAT;
          rd_load      = 1'b1;
          rd_load_last = (rlen_q == 8'd0);
        end else begin
          rwait_d = rwait_q - 4'd1;
        end
      end
      R_BEAT: begin
        if (rready) begin
          if (rcnt_q == rlen_q) begin
            rd_state_d = R_IDLE;
            rlast_d    = 1'b0;
          end else begin
            raddr_d      = rnext;
            rcnt_d       = rcnt_q + 8'd1;
            rd_load      = 1'b1;
            rd_load_addr = rnext;
            rd_load_last = ((rcnt_q + 8'd1) == rlen_q);
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    // Array is read before this edge's write lands, so a same-cycle write to this word is not seen.
    r_idx = word_index(rd_load_addr, BASE);
    r_in  = (r_idx < 32'(DEPTH));
    if (rd_load) begin
      rdata_d = r_in ? mem[r_idx[AW-1:0]] : 32'd0;
      rresp_d = r_in ? RESP_OKAY : RESP_DECERR;
      rlast_d = rd_load_last;
    end
    arready_d = (rd_state_d == R_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state_q <= R_IDLE;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rburst_q   <= '0;
      rcnt_q     <= '0;
      rwait_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
      arready_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rburst_q   <= rburst_d;
      rcnt_q     <= rcnt_d;
      rwait_q    <= rwait_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      arready_q  <= arready_d;
    end
  end

  assign w_idx = word_index(waddr_q, BASE);
  assign w_in  = (w_idx < 32'(DEPTH));
  assign w_end = wlast || (wcnt_q == wlen_q);

  always_comb begin
    wr_state_d = wr_state_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wcnt_d     = wcnt_q;
    werr_d     = werr_q;
    mem_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          waddr_d    = awaddr;
          wlen_d     = awlen;
          wcnt_d     = 8'd0;
          werr_d     = RESP_OKAY;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          mem_we = w_in;
          if (!w_in) werr_d = RESP_DECERR;
          if (w_end) begin
            // wlast and the beat count disagreeing is a protocol error, unless already DECERR.
            if ((werr_d != RESP_DECERR) && (wlast != (wcnt_q == wlen_q))) werr_d = RESP_SLVERR;
            wr_state_d = W_RESP;
          end else begin
            waddr_d = wnext;
            wcnt_d  = wcnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = (wr_state_d == W_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state_q <= W_IDLE;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wcnt_q     <= '0;
      werr_q     <= RESP_OKAY;
      awready_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wcnt_q     <= wcnt_d;
      werr_q     <= werr_d;
      awready_q  <= awready_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_idx[AW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = (rd_state_q == R_BEAT);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign awready = awready_q;
  assign wready  = (wr_state_q == W_DATA);
  assign bvalid  = (wr_state_q == W_RESP);
  assign bresp   = werr_q;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Self-checking bench for axi4_mem_slave: reset state, read/write bursts against a
// word-level memory model, a vector table of read bursts, directed corners and random traffic.
module tb_axi4_mem_slave;

  localparam int          DEPTH  = 16384;
  localparam logic [31:0] BASE   = 32'h1c00_0000;
  localparam int          RD_LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  axi4_mem_slave #(.DEPTH(DEPTH), .BASE(BASE), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]       a;
    logic [7:0]        l;
    logic [1:0]        b;
    logic [3:0][31:0]  e;
  } rvec_t;

  rvec_t       tbl [8];
  logic [31:0] model [int unsigned];
  logic [31:0] got_d[$];
  logic [1:0]  got_r[$];
  logic        got_l[$];
  logic [31:0] wq_d[$];
  logic [3:0]  wq_s[$];
  int          total = 0;
  int          bad = 0;
  int          lat, rcyc;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic in_rng(input logic [31:0] ad);
    logic [31:0] w;
    w = (ad - BASE) >> 2;
    return w < DEPTH;
  endfunction

  // {resp, data} the memory should return for a beat at byte address ad
  function automatic logic [33:0] model_rd(input logic [31:0] ad);
    logic [31:0] w;
    w = (ad - BASE) >> 2;
    if (!in_rng(ad)) return {2'd3, 32'd0};
    if (model.exists(w)) return {2'd0, model[w]};
    return {2'd0, 32'd0};
  endfunction

  // Byte address of beat i, written from the burst-type rules rather than bit masks
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] l,
                                            input logic [1:0] b, input int i);
    int unsigned n, w;
    logic [31:0] lo;
    n = int'(l) + 1;
    if (b == 2'd0) return a;
    if (b == 2'd2 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
      w  = n * 4;
      lo = a - (a % w);
      return lo + (((a - lo) + 4 * i) % w);
    end
    return a + 4 * i;
  endfunction

  function automatic rvec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
    rvec_t v;
    v.a = a; v.l = l; v.b = b;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    return v;
  endfunction

  task automatic do_read(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                         input bit usepat, input logic [15:0] pat, input int pct);
    int guard, cyc;
    logic held, rr, hl;
    logic [31:0] hd;
    logic [1:0] hr;
    got_d.delete(); got_r.delete(); got_l.delete();
    araddr = a; arlen = l; arburst = b; arvalid = 1'b1; rready = 1'b0;
    guard = 0;
    while (!arready && guard < 50) begin step(); guard++; end
    chk("ar_accept", arready, 1'b1);
    step();
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 40) begin step(); lat++; end
    chk("r_first_valid", rvalid, 1'b1);
    cyc = 0; held = 1'b0; hd = '0; hr = '0; hl = 1'b0;
    while (got_d.size() < int'(l) + 1 && cyc < 2000) begin
      if (held) begin
        chk("r_hold_valid", rvalid, 1'b1);
        chk("r_hold_data", rdata, hd);
        chk("r_hold_resp", rresp, hr);
        chk("r_hold_last", rlast, hl);
      end
      if (usepat) rr = (cyc < 16) ? pat[cyc] : 1'b1;
      else        rr = ($urandom_range(0, 99) >= pct);
      rready = rr;
      held = 1'b0;
      if (rvalid) begin
        if (rr) begin
          got_d.push_back(rdata); got_r.push_back(rresp); got_l.push_back(rlast);
        end else begin
          hd = rdata; hr = rresp; hl = rlast; held = 1'b1;
        end
      end
      step();
      cyc++;
    end
    rready = 1'b0;
    rcyc = cyc;
    chk("r_end_rvalid", rvalid, 1'b0);
    chk("r_end_arready", arready, 1'b1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input int pct);
    logic [33:0] e;
    do_read(a, l, b, 1'b0, 16'h0, pct);
    chk("r_count", got_d.size(), int'(l) + 1);
    for (int i = 0; i < got_d.size() && i <= int'(l); i++) begin
      e = model_rd(beat_addr(a, l, b, i));
      chk("r_data", got_d[i], e[31:0]);
      chk("r_resp", got_r[i], e[33:32]);
      chk("r_last", got_l[i], i == int'(l));
    end
  endtask

  // wl: beat index carrying wlast (-1 = never); beats come from wq_d/wq_s
  task automatic wr(input logic [31:0] a, input int l, input int wl, input int bdly);
    int nb, sent, guard;
    logic hs, dec;
    logic [1:0] eresp;
    logic [31:0] ad, w;
    nb  = (wl >= 0 && wl < l) ? wl + 1 : l + 1;
    dec = 1'b0;
    for (int i = 0; i < nb; i++) if (!in_rng(a + 4 * i)) dec = 1'b1;
    eresp = dec ? 2'd3 : ((wl == l) ? 2'd0 : 2'd2);
    awaddr = a; awlen = 8'(l); awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 50) begin step(); guard++; end
    chk("aw_accept", awready, 1'b1);
    step();
    awvalid = 1'b0;
    sent = 0; guard = 0;
    while (!bvalid && guard < 200) begin
      wdata = wq_d[sent]; wstrb = wq_s[sent]; wlast = (sent == wl); wvalid = 1'b1;
      hs = wready;
      step();
      if (hs) sent++;
      guard++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("w_beats", sent, nb);
    chk("b_valid", bvalid, 1'b1);
    chk("b_resp", bresp, eresp);
    for (int k = 0; k < bdly; k++) begin
      step();
      chk("b_hold", {bvalid, bresp}, {1'b1, eresp});
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("b_end_bvalid", bvalid, 1'b0);
    chk("b_end_awready", awready, 1'b1);
    for (int i = 0; i < nb; i++) begin
      ad = a + 4 * i;
      if (in_rng(ad)) begin
        w = (ad - BASE) >> 2;
        for (int j = 0; j < 4; j++) if (wq_s[i][j]) model[w][8*j +: 8] = wq_d[i][8*j +: 8];
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int guard;
    logic [1:0]  rb;
    logic [7:0]  rl;
    logic [31:0] ra;
    logic [33:0] e;
    int          wl;

    reset = 1'b0;
    araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    wvalid = 1'b0; bready = 1'b0;
    step(); step();
    chk("rst_arready", arready, 1'b0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", {rresp, bresp}, 4'd0);
    #2 reset = 1'b1;
    step();
    chk("rel_arready", arready, 1'b1);
    chk("rel_awready", awready, 1'b1);

    // Preload words 0..63 with 0x9C+i (words 4..7 hold A0..A3) and the last word
    for (int blk = 0; blk < 4; blk++) begin
      wq_d.delete(); wq_s.delete();
      for (int i = 0; i < 16; i++) begin
        wq_d.push_back(32'h9C + 32'(blk * 16 + i)); wq_s.push_back(4'hF);
      end
      wr(BASE + 32'(64 * blk), 15, 15, 0);
    end
    wq_d = '{32'h5A5A_0000}; wq_s = '{4'hF};
    wr(BASE + 32'(4 * (DEPTH - 1)), 0, 0, 0);

    // INCR latency and back-to-back beats
    do_read(BASE + 32'h10, 8'd3, 2'd1, 1'b0, 16'h0, 0);
    chk("lat_first_rvalid", lat, RD_LAT + 1);
    chk("b2b_cycles", rcyc, 4);
    chk("b2b_count", got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      chk("incr_data", got_d[i], 32'hA0 + 32'(i));
      chk("incr_last", got_l[i], i == 3);
    end

    // rready 1-0-0-1 stall pattern
    do_read(BASE + 32'h10, 8'd3, 2'd1, 1'b1, 16'hFFF9, 0);
    chk("stall_cycles", rcyc, 6);
    chk("stall_count", got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) chk("stall_data", got_d[i], 32'hA0 + 32'(i));

    tbl[0] = mk(BASE + 32'h10, 8'd3, 2'd1, BASE + 32'h10, BASE + 32'h14, BASE + 32'h18, BASE + 32'h1c);
    tbl[1] = mk(BASE + 32'h18, 8'd3, 2'd2, BASE + 32'h18, BASE + 32'h1c, BASE + 32'h10, BASE + 32'h14);
    tbl[2] = mk(BASE + 32'h18, 8'd3, 2'd0, BASE + 32'h18, BASE + 32'h18, BASE + 32'h18, BASE + 32'h18);
    tbl[3] = mk(BASE + 32'h04, 8'd1, 2'd2, BASE + 32'h04, BASE + 32'h00, 32'h0, 32'h0);
    tbl[4] = mk(BASE + 32'h08, 8'd2, 2'd2, BASE + 32'h08, BASE + 32'h0c, BASE + 32'h10, 32'h0);
    tbl[5] = mk(BASE - 32'h8, 8'd3, 2'd1, BASE - 32'h8, BASE - 32'h4, BASE, BASE + 32'h4);
    tbl[6] = mk(BASE - 32'h4, 8'd0, 2'd1, BASE - 32'h4, 32'h0, 32'h0, 32'h0);
    tbl[7] = mk(BASE + 32'(4 * DEPTH - 4), 8'd1, 2'd1, BASE + 32'(4 * DEPTH - 4),
                BASE + 32'(4 * DEPTH), 32'h0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      do_read(tbl[k].a, tbl[k].l, tbl[k].b, 1'b0, 16'h0, 25);
      chk("tbl_count", got_d.size(), int'(tbl[k].l) + 1);
      for (int i = 0; i < got_d.size() && i <= int'(tbl[k].l); i++) begin
        e = model_rd(tbl[k].e[i]);
        chk("tbl_data", got_d[i], e[31:0]);
        chk("tbl_resp", got_r[i], e[33:32]);
        chk("tbl_last", got_l[i], i == int'(tbl[k].l));
      end
    end
    do_read(BASE - 32'h4, 8'd0, 2'd1, 1'b0, 16'h0, 0);
    chk("below_base_data", got_d.size() > 0 ? got_d[0] : 32'hBAD, 32'h0);
    chk("below_base_resp", got_r.size() > 0 ? got_r[0] : 2'd1, 2'd3);

    // Byte strobes over an all-ones fill, response held under bready back-pressure
    wq_d = '{32'hFFFF_FFFF, 32'hFFFF_FFFF}; wq_s = '{4'hF, 4'hF};
    wr(BASE + 32'h8, 1, 1, 0);
    wq_d = '{32'h1122_3344, 32'h5566_7788}; wq_s = '{4'b0011, 4'b1111};
    wr(BASE + 32'h8, 1, 1, 3);
    do_read(BASE + 32'h8, 8'd1, 2'd1, 1'b0, 16'h0, 0);
    chk("strb_word0", got_d.size() > 1 ? got_d[0] : 32'hBAD, 32'hFFFF_3344);
    chk("strb_word1", got_d.size() > 1 ? got_d[1] : 32'hBAD, 32'h5566_7788);

    // Out-of-range write must not alias into the array
    wq_d = '{32'hDEAD_BEEF}; wq_s = '{4'hF};
    wr(BASE + 32'(4 * DEPTH), 0, 0, 1);
    rd(BASE, 8'd0, 2'd1, 0);
    chk("decerr_no_alias", got_d.size() > 0 ? got_d[0] : 32'hBAD, 32'h9C);

    // wlast / length disagreement and DECERR priority
    wq_d = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303}; wq_s = '{4'hF, 4'hF, 4'hF};
    wr(BASE + 32'h80, 2, 1, 0);
    wr(BASE + 32'h90, 0, -1, 0);
    wr(BASE - 32'h4, 1, 0, 0);
    rd(BASE + 32'h80, 8'd3, 2'd1, 0);
    rd(BASE + 32'h90, 8'd0, 2'd1, 0);

    // Read and write bursts in flight together
    wq_d = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
    wq_s = '{4'hF, 4'hF, 4'hF, 4'hF};
    fork
      rd(BASE, 8'd7, 2'd1, 20);
      wr(BASE + 32'hA0, 3, 3, 2);
    join
    rd(BASE + 32'hA0, 8'd3, 2'd1, 0);

    // Reset in the middle of a stalled read burst
    araddr = BASE + 32'h10; arlen = 8'd3; arburst = 2'd1; arvalid = 1'b1; rready = 1'b0;
    guard = 0;
    while (!arready && guard < 50) begin step(); guard++; end
    step();
    arvalid = 1'b0;
    guard = 0;
    while (!rvalid && guard < 40) begin step(); guard++; end
    chk("mid_rst_started", rvalid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_arready", arready, 1'b0);
    chk("mid_rst_rdata", rdata, 32'h0);
    @(posedge clock);
    #2 reset = 1'b1;
    step();
    chk("post_rst_arready", arready, 1'b1);
    chk("post_rst_rvalid", rvalid, 1'b0);
    rd(BASE + 32'h10, 8'd3, 2'd1, 0);

    // Random traffic inside the preloaded window
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        rl = 8'($urandom_range(0, 3));
        wq_d.delete(); wq_s.delete();
        for (int i = 0; i <= int'(rl); i++) begin
          wq_d.push_back($urandom()); wq_s.push_back(4'($urandom_range(0, 15)));
        end
        wl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : int'(rl);
        wr(BASE + 32'(4 * $urandom_range(0, 60)), int'(rl), wl, int'($urandom_range(0, 2)));
      end else begin
        ra = BASE + 32'(4 * $urandom_range(0, 47));
        rl = 8'($urandom_range(0, 15));
        rb = 2'($urandom_range(0, 2));
        rd(ra, rl, rb, 30);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
